// File: rtl/final_permutation_stage.sv
// final_permutation_stage: DES output swap + IP^-1 with a 2-entry valid/ready output FIFO.
module final_permutation_stage #(
    parameter bit SWAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] left_half,
    input  logic [31:0] right_half,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_text,
    output logic [1:0]  occupancy,
    output logic [15:0] blk_cnt
);
    logic [63:0] pre, perm;
    logic [63:0] mem_q [2];
    logic [63:0] mem_d [2];
    logic        wr_q, wr_d, rd_q, rd_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] blk_q, blk_d;
    logic        push, pop;

    assign pre = SWAP ? {right_half, left_half} : {left_half, right_half};

    // FP[k] for row r, column c is (c even ? 40 : 8) + 8*(c/2) - r
    for (genvar k = 0; k < 64; k++) begin : g_fp
        localparam int R = k / 8;
        localparam int C = k % 8;
        localparam int F = ((C % 2 == 0) ? 40 : 8) + 8 * (C / 2) - R;
        assign perm[63 - k] = pre[64 - F];
    end

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_text  = mem_q[rd_q];
    assign occupancy = cnt_q;
    assign blk_cnt   = blk_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = perm;
        wr_d  = push ? ~wr_q : wr_q;
        rd_d  = pop ? ~rd_q : rd_q;
        cnt_d = (push && !pop) ? cnt_q + 2'd1 : (pop && !push) ? cnt_q - 2'd1 : cnt_q;
        blk_d = pop ? blk_q + 16'd1 : blk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
            blk_q    <= 16'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end
endmodule
